// File: rtl/alu_result_packer_if.sv
// alu_result_packer_if: ALU result capture, UART byte stream and FIFO status signals
interface alu_result_packer_if #(
   parameter int WIDTH = 16,
   parameter int DATA_W = 8
);
   logic [WIDTH-1:0] alu_out;
   logic alu_valid;
   logic tx_ready;
   logic ovf_clr;
   logic [DATA_W-1:0] tx_data;
   logic tx_valid;
   logic fifo_full;
   logic fifo_empty;
   logic overflow;
   modport master (
      output alu_out, alu_valid, tx_ready, ovf_clr,
      input tx_data, tx_valid, fifo_full, fifo_empty, overflow
   );
   modport slave (
      input alu_out, alu_valid, tx_ready, ovf_clr,
      output tx_data, tx_valid, fifo_full, fifo_empty, overflow
   );
endinterface

// File: rtl/alu_result_packer.sv
// alu_result_packer: FIFO-buffers ALU results and serialises them LSB-first into UART bytes; RESULT_CHECKSUM_EN appends an XOR checksum byte per word
module alu_result_packer #(
   parameter int WIDTH = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   alu_result_packer_if.slave bus
);
   localparam int NB = WIDTH / DATA_W;
   localparam int AW = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
`ifdef RESULT_CHECKSUM_EN
   localparam int NBYTES = NB + 1;
   localparam int SR_W = WIDTH + DATA_W;
`else
   localparam int NBYTES = NB;
   localparam int SR_W = WIDTH;
`endif
   localparam int CW = $clog2(NBYTES + 1);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic [SR_W-1:0] shift_reg, load_word;
   logic [CW-1:0] byte_cnt;
   logic full_q, empty_q, ovf_q, push, drop, pop, xfer, last;
   assign push = bus.alu_valid && count != CNT_W'(DEPTH);
   assign drop = bus.alu_valid && count == CNT_W'(DEPTH);
   assign pop = state == IDLE && !empty_q;
   assign xfer = state == SEND && bus.tx_ready;
   assign last = byte_cnt == CW'(NBYTES - 1);
   assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
   assign bus.tx_valid = state == SEND;
   assign bus.tx_data = shift_reg[DATA_W-1:0];
   assign bus.fifo_full = full_q;
   assign bus.fifo_empty = empty_q;
   assign bus.overflow = ovf_q;
`ifdef RESULT_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
   // XOR of the head word's data bytes, parked above them so it shifts out last
   always_comb begin
      csum = '0;
      for (int i = 0; i < NB; i++) csum ^= mem[rd_ptr][i*DATA_W +: DATA_W];
   end
   assign load_word = {csum, mem[rd_ptr]};
`else
   assign load_word = mem[rd_ptr];
`endif
   // next state: pop starts a word, the last accepted byte returns to IDLE
   always_comb begin
      state_nxt = state;
      if (pop) state_nxt = SEND;
      else if (xfer && last) state_nxt = IDLE;
   end
   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   // FIFO storage; contents are don't-care until written, pointers guard them
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.alu_out;
   end
   // FIFO pointers, status flags, sticky overflow and the byte serialiser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         full_q <= 1'b0;
         empty_q <= 1'b1;
         ovf_q <= 1'b0;
         shift_reg <= '0;
         byte_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full_q <= count_nxt == CNT_W'(DEPTH);
         empty_q <= count_nxt == '0;
         ovf_q <= drop || (ovf_q && !bus.ovf_clr);
         if (pop) begin
            shift_reg <= load_word;
            byte_cnt <= '0;
         end else if (xfer) begin
            shift_reg <= shift_reg >> DATA_W;
            byte_cnt <= byte_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_alu_result_packer.sv
// tb_alu_result_packer: directed scoreboard bench for alu_result_packer (honours RESULT_CHECKSUM_EN)
module tb_alu_result_packer;
   localparam int WIDTH = 16;
   localparam int DATA_W = 8;
   localparam int DEPTH = 4;
`ifdef RESULT_CHECKSUM_EN
   localparam int BPW = 3;
`else
   localparam int BPW = 2;
`endif
   logic clk = 1'b0;
   logic rst;
   int errors = 0;
   int checks = 0;
   int xfers = 0;
   logic [7:0] exp_q [$];
   alu_result_packer_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();
   alu_result_packer #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic push_exp(input logic [15:0] w);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
`ifdef RESULT_CHECKSUM_EN
      exp_q.push_back(w[7:0] ^ w[15:8]);
`endif
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [15:0] w);
      bus.alu_out = w;
      bus.alu_valid = 1'b1;
      tick();
      bus.alu_valid = 1'b0;
   endtask
   task automatic wait_valid();
      int k = 0;
      while (!bus.tx_valid && k < 20) begin
         tick();
         k++;
      end
      check("valid_timeout", bus.tx_valid, 1);
   endtask
   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || bus.tx_valid || !bus.fifo_empty) && k < 100) begin
         tick();
         k++;
      end
      check("drain_left", exp_q.size(), 0);
      check("drain_idle", bus.tx_valid, 0);
   endtask
   int bidx = 0;
   logic gap_chk = 1'b0;
   logic stall_prev = 1'b0;
   logic [7:0] stall_data;
   // monitor: compares every accepted byte with the scoreboard, checks hold and inter-word gap
   always @(negedge clk) begin
      if (rst) begin
         bidx = 0;
         gap_chk = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (gap_chk) begin
            check("idle_gap", bus.tx_valid, 0);
            gap_chk = 1'b0;
         end
         if (stall_prev) begin
            check("valid_held", bus.tx_valid, 1);
            check("data_held", bus.tx_data, stall_data);
         end
         if (bus.tx_valid && bus.tx_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
            end else check("tx_byte", bus.tx_data, exp_q.pop_front());
            bidx++;
            if (bidx == BPW) begin
               bidx = 0;
               gap_chk = 1'b1;
            end
            stall_prev = 1'b0;
         end else begin
            stall_prev = bus.tx_valid;
            stall_data = bus.tx_data;
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int x0;
      rst = 1'b0;
      bus.alu_out = 16'h1234;
      bus.alu_valid = 1'b1;
      bus.tx_ready = 1'b1;
      bus.ovf_clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", bus.tx_valid, 0);
      check("async_rst_empty", bus.fifo_empty, 1);
      check("async_rst_ovf", bus.overflow, 0);
      check("async_rst_data", bus.tx_data, 0);
      check("async_rst_full", bus.fifo_full, 0);
      repeat (3) begin
         tick();
         check("rst_valid", bus.tx_valid, 0);
         check("rst_empty", bus.fifo_empty, 1);
         check("rst_ovf", bus.overflow, 0);
      end
      rst = 1'b0;
      bus.alu_valid = 1'b0;
      tick();
      check("post_rst_empty", bus.fifo_empty, 1);
      check("post_rst_valid", bus.tx_valid, 0);
      // single word with tx_ready high, including first-byte latency
      x0 = xfers;
      push_exp(16'hA5C3);
      send(16'hA5C3);
      check("lat_k_valid", bus.tx_valid, 0);
      check("lat_k_empty", bus.fifo_empty, 0);
      tick();
      check("lat_k1_valid", bus.tx_valid, 1);
      check("lat_k1_data", bus.tx_data, 8'hC3);
      check("lat_k1_empty", bus.fifo_empty, 1);
      drain();
      check("single_count", xfers - x0, BPW);
      // back-pressure holds the byte
      bus.tx_ready = 1'b0;
      push_exp(16'h00FF);
      send(16'h00FF);
      wait_valid();
      repeat (5) tick();
      check("bp_data", bus.tx_data, 8'hFF);
      check("bp_valid", bus.tx_valid, 1);
      bus.tx_ready = 1'b1;
      drain();
      // overflow: a stalled lead word occupies the serialiser, then fill and overrun the FIFO
      bus.tx_ready = 1'b0;
      push_exp(16'h0F0F);
      send(16'h0F0F);
      wait_valid();
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) push_exp(16'(i));
         bus.ovf_clr = (i == 6);
         send(16'(i));
         bus.ovf_clr = 1'b0;
         if (i == 4) check("ovf_not_yet", bus.overflow, 0);
      end
      check("ovf_full", bus.fifo_full, 1);
      check("ovf_set", bus.overflow, 1);
      check("ovf_nonempty", bus.fifo_empty, 0);
      bus.tx_ready = 1'b1;
      drain();
      check("ovf_sticky", bus.overflow, 1);
      check("ovf_not_full", bus.fifo_full, 0);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", bus.overflow, 0);
      // reset in the middle of a word discards it and the queued word
      bus.tx_ready = 1'b0;
      push_exp(16'hBEEF);
      push_exp(16'hCAFE);
      send(16'hBEEF);
      send(16'hCAFE);
      wait_valid();
      bus.tx_ready = 1'b1;
      tick();
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_valid", bus.tx_valid, 0);
      check("midrst_empty", bus.fifo_empty, 1);
      tick();
      rst = 1'b0;
      x0 = xfers;
      push_exp(16'h1111);
      send(16'h1111);
      drain();
      check("after_rst_count", xfers - x0, BPW);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
